// File: rtl/uart_pkg.sv
// Shared types, line levels and parity helper for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  function automatic logic parity_reduce(input logic [7:0] data, input logic par_bit);
    return (^data) ^ par_bit;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the rx pin plus a previous-value flop for start-edge detection.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  output logic line_s,
  output logic fall_edge
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Synchroniser chain; every stage resets to the idle line level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= LINE_IDLE;
      sync2_q <= LINE_IDLE;
      prev_q  <= LINE_IDLE;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign line_s    = sync2_q;
  assign fall_edge = (sync2_q == LINE_START) && (prev_q == LINE_IDLE);

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver with a one-entry valid/ready holding register (8N1 by default).
// Optional parity stage is enabled by defining UART_RX_PARITY_EN.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 104,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       rx_ready,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,output logic      parity_err
`endif
);

  localparam int               CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(BAUD_DIV - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);
  localparam int               RJ       = 8 - DATA_BITS;
`ifdef UART_RX_PARITY_EN
  localparam rx_state_e        AFTER_DATA = ST_PARITY;
  localparam logic             PAR_ODD    = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
`else
  localparam rx_state_e        AFTER_DATA = ST_STOP;
`endif

  logic line_s;
  logic fall_edge_s;

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic             good_s;
  logic             hs_s;
  logic             par_ok_s;
  logic [7:0]       rjust_s;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d;
  logic             perr_q, perr_d;
`endif

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .line_s    (line_s),
    .fall_edge (fall_edge_s)
  );

  assign hs_s    = valid_q & rx_ready;
  assign rjust_s = shift_q >> RJ;
`ifdef UART_RX_PARITY_EN
  assign par_ok_s = (parity_reduce(rjust_s, par_q) == PAR_ODD);
`else
  assign par_ok_s = 1'b1;
`endif

  // Frame FSM next state: the baud counter restarts on every state entry and sample point
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_ONE;
    bit_d   = bit_q;
    shift_d = shift_q;
    ferr_d  = 1'b0;
    good_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = CNT_ZERO;
        if (fall_edge_s) state_d = ST_START;
        else             state_d = ST_IDLE;
      end
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = CNT_ZERO;
          bit_d = 3'd0;
          if (line_s == LINE_START) state_d = ST_DATA;
          else                      state_d = ST_IDLE;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = CNT_ZERO;
          shift_d = {line_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == LAST_BIT) state_d = AFTER_DATA;
          else                   state_d = ST_DATA;
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = CNT_ZERO;
          par_d   = line_s;
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = CNT_ZERO;
          state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
          perr_d  = ~par_ok_s;
`endif
          if (line_s == LINE_STOP) good_s = par_ok_s;
          else                     ferr_d = 1'b1;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Holding register: a handshake frees the slot in the same cycle a new frame lands
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (err_clr) overrun_d = 1'b0;
    else         overrun_d = overrun_q;
    if (hs_s) valid_d = 1'b0;
    else      valid_d = valid_q;
    if (good_s) begin
      if (!valid_q || hs_s) begin
        data_d  = rjust_s;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else begin
      data_d = data_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core (BAUD_DIV=16, 8 data bits, even parity when enabled).
module tb_uart_rx_core;

  localparam int BD = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       rx_ready;
  logic       err_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int checks = 0;
  int failures = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  int rise_cnt = 0;
  int lat_meas = 154 + (PAR_EN ? BD : 0);
  logic valid_prev = 1'b0;
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  uart_rx_core #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY_ODD(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .rx_ready  (rx_ready),
    .err_clr   (err_clr),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
`ifdef UART_RX_PARITY_EN
    ,.parity_err(parity_err)
`endif
  );

  // Observer: counts pulses and records every byte handed over on a handshake
  always @(negedge clk) begin
    if (rst) begin
      valid_prev = 1'b0;
    end else begin
      if (frame_err) fe_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) pe_cnt++;
`endif
      if (rx_valid && !valid_prev) rise_cnt++;
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      valid_prev = rx_valid;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one whole frame; the line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit bad_par);
    logic par;
    par = (^d) ^ bad_par;
    rx_in = 1'b0;
    wait_cyc(BD);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      wait_cyc(BD);
    end
    if (PAR_EN) begin
      rx_in = par;
      wait_cyc(BD);
    end
    rx_in = stop;
    wait_cyc(BD);
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_in = 1'b1; rx_ready = 1'b1; err_clr = 1'b0;
    wait_cyc(3);
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%0h exp=0", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%0b exp=0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%0b exp=0", frame_err); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    rst = 1'b0;
    wait_cyc(2 * BD);
  endtask

  task automatic test_basic;
    int cyc, fe0, n0, lat, lo;
    logic [7:0] seen;
    fe0 = fe_cnt; n0 = got_q.size(); cyc = 0; seen = 8'h00;
    lo = 152 + (PAR_EN ? BD : 0);
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        while (!rx_valid && cyc < 400) begin @(negedge clk); cyc++; end
        seen = rx_data;
      end
    join
    lat = cyc - 1;
    checks++; if (lat < lo || lat > lo + 4) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d..%0d", lat, lo, lo + 4); end
    else lat_meas = lat;
    checks++; if (seen !== 8'hA5) begin failures++; $display("FAIL basic_data got=%0h exp=a5", seen); end
    checks++; if (fe_cnt - fe0 != 0) begin failures++; $display("FAIL basic_frame_err got=%0d exp=0", fe_cnt - fe0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_idle got=%0b exp=0", busy); end
    checks++; if (got_q.size() != n0 + 1) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size() - n0, 1); end
    wait_cyc(BD);
  endtask

  task automatic test_glitch;
    int fe0, r0;
    fe0 = fe_cnt; r0 = rise_cnt;
    rx_in = 1'b0;
    wait_cyc(4);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_rise got=%0b exp=1", busy); end
    rx_in = 1'b1;
    wait_cyc(8);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_fall got=%0b exp=0", busy); end
    wait_cyc(3 * BD);
    checks++; if (rise_cnt != r0) begin failures++; $display("FAIL glitch_valid got=%0d exp=%0d", rise_cnt - r0, 0); end
    checks++; if (fe_cnt != fe0) begin failures++; $display("FAIL glitch_frame_err got=%0d exp=%0d", fe_cnt - fe0, 0); end
  endtask

  task automatic test_break;
    int fe0, r0, n0;
    fe0 = fe_cnt; r0 = rise_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_cyc(40);
    checks++; if (fe_cnt - fe0 != 1) begin failures++; $display("FAIL break_ferr_cycles got=%0d exp=1", fe_cnt - fe0); end
    checks++; if (rise_cnt != r0) begin failures++; $display("FAIL break_valid got=%0d exp=0", rise_cnt - r0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL break_retrigger got=%0b exp=0", busy); end
    rx_in = 1'b1;
    wait_cyc(2 * BD);
    n0 = got_q.size();
    send_frame(8'h55, 1'b1, 1'b0);
    wait_cyc(4);
    checks++; if (got_q.size() != n0 + 1 || got_q[got_q.size() - 1] !== 8'h55) begin
      failures++; $display("FAIL break_next_frame got_n=%0d exp_n=1", got_q.size() - n0);
    end
    checks++; if (fe_cnt - fe0 != 1) begin failures++; $display("FAIL break_next_ferr got=%0d exp=1", fe_cnt - fe0); end
  endtask

  task automatic test_overrun;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    wait_cyc(BD);
    send_frame(8'h22, 1'b1, 1'b0);
    wait_cyc(4);
    checks++; if (rx_data !== 8'h11) begin failures++; $display("FAIL ovr_data_kept got=%0h exp=11", rx_data); end
    checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%0b exp=1", rx_valid); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%0b exp=1", overrun); end
    rx_ready = 1'b1;
    wait_cyc(1);
    rx_ready = 1'b0;
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL ovr_drain got=%0b exp=0", rx_valid); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%0b exp=1", overrun); end
    err_clr = 1'b1;
    wait_cyc(1);
    err_clr = 1'b0;
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%0b exp=0", overrun); end
    wait_cyc(BD);
  endtask

  task automatic test_back_to_back;
    rx_ready = 1'b0;
    send_frame(8'h66, 1'b1, 1'b0);
    wait_cyc(BD);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h66) begin failures++; $display("FAIL b2b_preload got=%0h exp=66", rx_data); end
    fork
      send_frame(8'h77, 1'b1, 1'b0);
      begin
        wait_cyc(lat_meas - 1);
        rx_ready = 1'b1;
        wait_cyc(1);
        rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%0b exp=1", rx_valid); end
        checks++; if (rx_data !== 8'h77) begin failures++; $display("FAIL b2b_data got=%0h exp=77", rx_data); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%0b exp=0", overrun); end
      end
    join
    checks++; if (got_q[got_q.size() - 1] !== 8'h66) begin failures++; $display("FAIL b2b_handshaken got=%0h exp=66", got_q[got_q.size() - 1]); end
    rx_ready = 1'b1;
    wait_cyc(2);
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b exp=0", rx_valid); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d;
    int n0;
    d = 8'hC3;
    rx_ready = 1'b1;
    rx_in = 1'b0;
    wait_cyc(BD);
    for (int i = 0; i < 3; i++) begin
      rx_in = d[i];
      wait_cyc(BD);
    end
    rx_in = d[3];
    wait_cyc(BD / 2);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmid_busy_before got=%0b exp=1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL rmid_rx_data got=%0h exp=0", rx_data); end
    checks++; if (rx_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      failures++; $display("FAIL rmid_flags got=%0b%0b%0b exp=000", rx_valid, frame_err, overrun);
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%0b exp=0", busy); end
    wait_cyc(3);
    rx_in = 1'b1;
    rst = 1'b0;
    wait_cyc(2 * BD);
    n0 = got_q.size();
    send_frame(8'h81, 1'b1, 1'b0);
    wait_cyc(4);
    checks++; if (got_q.size() != n0 + 1 || got_q[got_q.size() - 1] !== 8'h81) begin
      failures++; $display("FAIL rmid_next_frame got_n=%0d exp_n=1", got_q.size() - n0);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int pe0, r0;
    pe0 = pe_cnt; r0 = rise_cnt;
    send_frame(8'h81, 1'b1, 1'b1);
    wait_cyc(4);
    checks++; if (pe_cnt - pe0 != 1) begin failures++; $display("FAIL par_err_pulse got=%0d exp=1", pe_cnt - pe0); end
    checks++; if (rise_cnt != r0) begin failures++; $display("FAIL par_valid got=%0d exp=0", rise_cnt - r0); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL par_overrun got=%0b exp=0", overrun); end
  endtask
`endif

  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] d;
    int n0;
    bit done;
    done = 1'b0;
    n0 = got_q.size();
    fork
      begin
        for (int k = 0; k < 16; k++) begin
          d = 8'($urandom);
          exp_q.push_back(d);
          send_frame(d, 1'b1, 1'b0);
          wait_cyc($urandom_range(0, 20));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          rx_ready = 1'($urandom_range(0, 1));
          wait_cyc(1);
        end
      end
    join
    rx_ready = 1'b1;
    wait_cyc(4);
    checks++; if (got_q.size() - n0 != exp_q.size()) begin
      failures++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size() - n0, exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && n0 + k < got_q.size(); k++) begin
      checks++; if (got_q[n0 + k] !== exp_q[k]) begin
        failures++; $display("FAIL rand_byte%0d got=%0h exp=%0h", k, got_q[n0 + k], exp_q[k]);
      end
    end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rand_overrun got=%0b exp=0", overrun); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_break();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Full UART receiver, 8N1 by default. It is the receive-side counterpart of the team's UART transmitter, using the same BAUD_DIV timing. Synchronises the asynchronous serial line, validates the start bit at mid-bit, and samples data LSB-first at bit centres. Checks the stop bit and presents each byte through a one-entry valid/ready holding register, with framing and overrun status. Sits between the rx pin and host logic; the host's rx_data/rx_valid are driven from this block.

Parameters:
BAUD_DIV, 104, clk cycles per bit; must be ≥4 and even.
DATA_BITS, 8, data bits per frame, 5..8.
PARITY_ODD, 0, 1 = odd parity, 0 = even parity; used only with UART_RX_PARITY_EN.

Ports:
clk  input  1  clock.
rst  input  1  reset, asynchronous, active-high.
rx_in  input  1  serial line; idles high.
rx_ready  input  1  consumer accepts rx_data when high together with rx_valid.
err_clr  input  1  one-cycle clear of the sticky overrun flag.
rx_data  output  8  received byte, right-justified; bits above DATA_BITS are 0.
rx_valid  output  1  holding register full.
frame_err  output  1  one-cycle pulse on a bad stop bit.
overrun  output  1  sticky; a frame was dropped because the holding register was full.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, synchroniser flops=1, baud counter=0.
- Synchroniser: 2-FF chain plus one previous-value flop. A start edge is synced==0 while previous==1.
- Baud counter width is clog2(BAUD_DIV). It clears on every state entry.
- IDLE: on a start edge -> START.
- START: at count == BAUD_DIV/2-1, sample the line.
  - Sample 1 (glitch): return to IDLE, no outputs.
  - Sample 0: -> DATA, bit index=0.
- DATA: at count == BAUD_DIV-1, shift the sample into an 8-bit shift register (right-shift, new bit into MSB).
  - After DATA_BITS samples -> STOP (or PARITY when enabled).
- STOP: at count == BAUD_DIV-1, sample the line.
  - Sample 1: frame good; the data is right-justified (shift >> (8-DATA_BITS)) and offered to the holding register.
  - Sample 0: frame_err=1 for one cycle, data discarded.
  - Either way -> IDLE. A new start needs a fresh high-to-low edge, so a break does not retrigger.
- Latency: rx_valid rises 9.5*BAUD_DIV to 9.5*BAUD_DIV+4 clk cycles after the rx_in falling edge (8N1).
- Holding register:
  - Handshake = rx_valid && rx_ready. On a handshake with no new frame, rx_valid drops the next cycle.
  - Good frame with rx_valid=0: load it, rx_valid=1.
  - Good frame on the same cycle as a handshake: load the new byte, rx_valid stays 1, no overrun.
  - Good frame with rx_valid=1 and no handshake: keep the old byte, drop the new one, overrun=1.
  - rx_data is stable while rx_valid=1 and not handshaken.
- overrun clears on err_clr. If an overrun event coincides with err_clr, the set wins.
- rx_valid and overrun are unaffected by frame_err.
- Reset mid-frame: all state returns to reset values immediately; any partial byte is lost.

Optional Feature:
UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and samples at BAUD_DIV-1.
  - Parity is computed over the DATA_BITS data bits plus the parity bit. Mismatch against PARITY_ODD -> output port parity_err (1 bit) pulses for one cycle in the STOP-sample cycle. The byte is not loaded, and neither overrun nor rx_valid is affected.
  - Frame latency grows by BAUD_DIV.
- Undefined: no PARITY state, no parity_err port, PARITY_ODD ignored.

Decomposition:
- uart_pkg holds:
  - the rx state typedef (IDLE, START, DATA, PARITY, STOP) and its 3-bit encoding;
  - the start/data/stop line-level constants;
  - a parity-reduction function.
- One sub-module, uart_rx_sync: 2-FF synchroniser plus edge detect, with outputs line_s and fall_edge and async reset to 1.

Test Plan:
All scenarios use BAUD_DIV=16, DATA_BITS=8, rx_ready=1 unless stated.
- Frame 0xA5 8N1 -> rx_valid rises 152..156 cycles after the start edge; rx_data=0xA5; frame_err=0; busy then returns to 0.
- rx_in low for 4 cycles then high -> no rx_valid, no frame_err; busy falls by cycle 12.
- Frame 0x3C with stop bit 0 -> frame_err pulse of exactly 1 cycle; rx_valid stays 0. The line is held low 40 more cycles (no retrigger); a later frame 0x55 is received as 0x55.
- rx_ready=0; frames 0x11 then 0x22 -> rx_data=0x11, overrun=1. Then rx_ready=1 for 1 cycle -> rx_valid=0. Then err_clr -> overrun=0.
- Frame 0x77 completing on the same cycle as a handshake of 0x66 -> rx_data=0x77, rx_valid stays 1, overrun=0.
- Reset asserted during the 4th data bit, then frame 0x81 -> all outputs 0 during reset; 0x81 received correctly. With UART_RX_PARITY_EN and even parity, 0x81 with parity bit 1 -> parity_err pulse, rx_valid stays 0.
